// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage
// Contents: NB_WORD, NOP_INSTR, fetch_entry_t, PC helper functions.
package fetch_unit_pkg;

    localparam int NB_WORD = 32;

    // addi x0,x0,0
    localparam logic [NB_WORD-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [NB_WORD-1:0] pc;
        logic [NB_WORD-1:0] instruction;
    } fetch_entry_t;

    // Sequential PC, wraps modulo 2^32.
    function automatic logic [NB_WORD-1:0] pc_next(input logic [NB_WORD-1:0] pc);
        return pc + NB_WORD'(4);
    endfunction

    // Clears the byte-offset bits of a redirect target.
    function automatic logic [NB_WORD-1:0] pc_align(input logic [NB_WORD-1:0] pc);
        return pc & ~NB_WORD'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetched {pc, instruction} entries
// Ports: i_clock/i_reset (sync, active-high); i_push/i_push_data write an
// entry; i_pop removes the head; i_flush empties (beats a same-cycle push);
// o_head is the oldest entry; o_count/o_full/o_empty report occupancy.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_push  = i_push && !o_full;
        do_pop   = i_pop && !o_empty;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge i_clock) begin
        if (do_push && !i_flush) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch with redirect and stale-drop
// Ports: i_clock/i_reset (sync, active-high); o_imem_req/o_imem_addr/
// i_imem_gnt issue fetches; i_imem_rvalid/i_imem_rdata return words in order;
// i_redirect_valid/i_redirect_pc restart fetch; o_valid/o_instruction/o_pc
// with i_ready hand instructions to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                 DEPTH    = 2,
    parameter logic [NB_WORD-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    output logic               o_imem_req,
    output logic [NB_WORD-1:0] o_imem_addr,
    input  logic               i_imem_gnt,
    input  logic               i_imem_rvalid,
    input  logic [NB_WORD-1:0] i_imem_rdata,
    input  logic               i_redirect_valid,
    input  logic [NB_WORD-1:0] i_redirect_pc,
    output logic               o_valid,
    output logic [NB_WORD-1:0] o_instruction,
    output logic [NB_WORD-1:0] o_pc,
    input  logic               i_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [NB_WORD-1:0] fetch_pc_q, fetch_pc_d;
    logic [NB_WORD-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      drop_q, drop_d;
    logic [CW:0]        occupancy;
    logic               issue, resp;

    fetch_entry_t       fifo_head, fifo_push_data;
    logic [CW-1:0]      fifo_count;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_push     (fifo_push),
        .i_push_data(fifo_push_data),
        .i_pop      (fifo_pop),
        .i_flush    (i_redirect_valid),
        .o_head     (fifo_head),
        .o_count    (fifo_count),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    always_comb begin
        // Every fetch in flight reserves a buffer slot, so the FIFO never overflows.
        occupancy  = {1'b0, inflight_q} + {1'b0, fifo_count};
        o_imem_req = !i_reset && !i_redirect_valid && (occupancy < (CW + 1)'(DEPTH));
        issue      = o_imem_req && i_imem_gnt;
        // A response with nothing outstanding is illegal and ignored.
        resp       = i_imem_rvalid && (inflight_q != '0);

        fifo_push      = resp && (drop_q == '0) && !i_redirect_valid;
        fifo_push_data = '{pc: resp_pc_q, instruction: i_imem_rdata};
        fifo_pop       = o_valid && i_ready;

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + CW'(issue) - CW'(resp);
        drop_d     = drop_q;

        if (i_redirect_valid) begin
            fetch_pc_d = pc_align(i_redirect_pc);
            resp_pc_d  = pc_align(i_redirect_pc);
            // Every fetch still outstanding after this edge is stale; fetches
            // already marked for dropping are a subset of them, so the new
            // drop count is simply the surviving in-flight count.
            drop_d     = inflight_q - CW'(resp);
        end else begin
            if (issue) begin
                fetch_pc_d = pc_next(fetch_pc_q);
            end
            if (resp) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    resp_pc_d = pc_next(resp_pc_q);
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    assign o_imem_addr   = fetch_pc_q;
    assign o_valid       = !fifo_empty;
    assign o_instruction = o_valid ? fifo_head.instruction : NOP_INSTR;
    assign o_pc          = o_valid ? fifo_head.pc : '0;

    a_rvalid_has_outstanding: assert property (@(posedge i_clock) disable iff (i_reset)
        i_imem_rvalid |-> (inflight_q != '0));
    a_no_overflow: assert property (@(posedge i_clock) disable iff (i_reset)
        !(fifo_push && fifo_full && !fifo_pop));
    a_drop_bounded: assert property (@(posedge i_clock) disable iff (i_reset)
        (drop_q <= inflight_q) && (inflight_q <= CW'(DEPTH)));

endmodule
